ram_req_ctrl: RTL and testbench

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

---
 rtl/sim_ram_pkg.sv | 28 ++
 rtl/ram_rsp_fifo.sv | 76 +++++++
 rtl/ram_req_ctrl.sv | 98 +++++++++
 tb/tb_ram_req_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ram_pkg.sv
// Shared SimRAM helpers: word-size derivation, clog2 and the request opcode.
package sim_ram_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } ram_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    function automatic int data_width(input int dataSize);
        return 8 * dataSize;
    endfunction

    function automatic int addr_start(input int dataSize);
        return clog2(dataSize);
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Small synchronous FIFO holding read responses until the consumer takes them.
module ram_rsp_fifo
    import sim_ram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);
    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (doPop) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        if (doPush && !doPop) begin
            count_d = count_q + CW'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale entries are never visible because count gates them.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request front-end for the SimRAM: issues reads/writes and buffers read data
// in a credit-protected response FIFO so a stalled consumer never loses data.
module ram_req_ctrl
    import sim_ram_pkg::*;
#(
    parameter int DATA_SIZE  = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int RSP_DEPTH  = 2,
    localparam int DATA_WIDTH = data_width(DATA_SIZE),
    localparam int ADDR_START = addr_start(DATA_SIZE),
    localparam int AW         = ADDR_WIDTH - ADDR_START
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [AW-1:0]         ram_rd_addr,
    output logic [AW-1:0]         ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    input  logic                  ram_rd_valid
);

    localparam int CW = clog2(RSP_DEPTH + 1);

    ram_op_e       reqOp;
    logic          accept;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] fifoCnt;
    logic [CW:0]   credits;
    logic          fifoPush;
    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;

    // A read only issues if its data is guaranteed a FIFO slot; writes never wait.
    assign reqOp     = ram_op_e'(req_we);
    assign credits   = (CW + 1)'(RSP_DEPTH) - {1'b0, fifoCnt} - (CW + 1)'(inflight_q);
    assign req_ready = ~rst & ((reqOp == OP_WRITE) | (credits != '0));
    assign accept    = req_valid & req_ready;

    assign ram_rd_en   = accept & (reqOp == OP_READ);
    assign ram_wr_en   = accept & (reqOp == OP_WRITE);
    assign ram_rd_addr = req_addr;
    assign ram_wr_addr = req_addr;
    assign ram_wr_data = req_wdata;

    always_comb begin
        inflight_d = inflight_q;
        if (ram_rd_valid) begin
            inflight_d = 1'b0;
        end
        if (ram_rd_en) begin
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Data returning during reset belongs to a read that reset cancelled.
    assign fifoPush  = ram_rd_valid & ~rst;
    assign rsp_valid = ~fifoEmpty & ~rst;
    assign fifoPop   = rsp_valid & rsp_ready;

    ram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rspFifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifoPush),
        .wdata_i (ram_rd_data),
        .pop_i   (fifoPop),
        .rdata_o (rsp_rdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCnt)
    );

    unexpectedRdValid: assert property (@(posedge clk) disable iff (rst) ram_rd_valid |-> inflight_q);
    noFifoOverflow:    assert property (@(posedge clk) disable iff (rst) fifoPush |-> (!fifoFull || fifoPop));
    exclusiveRdWr:     assert property (@(posedge clk) !(ram_rd_en && ram_wr_en));

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a one-cycle-latency SimRAM model.
module tb_ram_req_ctrl;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          ram_rd_en;
    logic          ram_wr_en;
    logic [AW-1:0] ram_rd_addr;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data;
    logic          ram_rd_valid;

    logic          loadEn;
    logic [AW-1:0] loadAddr;
    logic [DW-1:0] loadData;
    logic [DW-1:0] ramMem [64];

    int checkCount;
    int failCount;
    int bothHigh;
    int overflowSeen;

    logic [AW-1:0] seqAddr [8];
    logic [DW-1:0] seqData [8];

    ram_req_ctrl #(
        .DATA_SIZE  (4),
        .ADDR_WIDTH (8),
        .RSP_DEPTH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .ram_rd_en    (ram_rd_en),
        .ram_wr_en    (ram_wr_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data  (ram_rd_data),
        .ram_rd_valid (ram_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SimRAM model: read data and valid appear the cycle after the read issues.
    always @(posedge clk) begin
        if (loadEn) begin
            ramMem[loadAddr] <= loadData;
        end else if (ram_wr_en) begin
            ramMem[ram_wr_addr] <= ram_wr_data;
        end
        ram_rd_valid <= ram_rd_en;
        if (ram_rd_en) begin
            ram_rd_data <= ramMem[ram_rd_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_rd_en && ram_wr_en) begin
            bothHigh++;
        end
        if (dut.u_rspFifo.count_o > 2'd2) begin
            overflowSeen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic rspReady);
        req_valid = valid;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = rspReady;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents n reads from seqAddr, holds rsp_ready low for stallCycles, then drains.
    task automatic runReadSeq(input int n, input int stallCycles, input string name);
        int issued;
        int got;
        issued = 0;
        got    = 0;
        for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
            if (issued < n) begin
                applyStimulus(1'b1, 1'b0, seqAddr[issued], '0, cyc >= stallCycles);
            end else begin
                applyStimulus(1'b0, 1'b0, '0, '0, cyc >= stallCycles);
            end
            @(negedge clk);
            if (stallCycles > 0 && cyc == stallCycles - 1) begin
                checkOutput({name, "_stall_issued"}, 32'(issued), 32'd2);
                checkOutput({name, "_stall_ready"}, 32'(req_ready), 32'd0);
                checkOutput({name, "_stall_count"}, 32'(dut.u_rspFifo.count_o), 32'd2);
                checkOutput({name, "_stall_head"}, rsp_rdata, seqData[0]);
            end
            if (rsp_valid && rsp_ready) begin
                checkOutput($sformatf("%s_rsp%0d", name, got), rsp_rdata, seqData[got]);
                got++;
            end
            if (req_valid && req_ready) begin
                issued++;
            end
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput({name, "_issued"}, 32'(issued), 32'(n));
        checkOutput({name, "_returned"}, 32'(got), 32'(n));
    endtask

    initial begin
        checkCount   = 0;
        failCount    = 0;
        bothHigh     = 0;
        overflowSeen = 0;
        rst          = 1'b1;
        loadEn       = 1'b0;
        loadAddr     = '0;
        loadData     = '0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

        // Reset: requests are refused and nothing reaches the RAM.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 6'd5, 32'h77, 1'b1);
        loadEn   = 1'b1;
        loadAddr = 6'd1;
        loadData = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_wr_en", 32'(ram_wr_en), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        nextCycle();
        loadEn = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'd5, '0, 1'b1);
        @(negedge clk);
        checkOutput("rst_rd_en", 32'(ram_rd_en), 32'd0);
        nextCycle();
        rst = 1'b0;

        // Single read of byte address 0x4 (word 1).
        applyStimulus(1'b1, 1'b0, 6'd1, '0, 1'b1);
        @(negedge clk);
        checkOutput("rd_first_ready", 32'(req_ready), 32'd1);
        checkOutput("rd_en", 32'(ram_rd_en), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("rd_n1_valid", 32'(rsp_valid), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd_n2_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_n2_data", rsp_rdata, 32'hDEADBEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("rd_n3_valid", 32'(rsp_valid), 32'd0);
        nextCycle();

        // Write then read the same word on the next cycle.
        applyStimulus(1'b1, 1'b1, 6'd3, 32'hA5, 1'b1);
        @(negedge clk);
        checkOutput("wr_en", 32'(ram_wr_en), 32'd1);
        checkOutput("wr_no_rd", 32'(ram_rd_en), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 6'd3, '0, 1'b1);
        @(negedge clk);
        checkOutput("wr_rd_en", 32'(ram_rd_en), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("wr_rd_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wr_rd_data", rsp_rdata, 32'hA5);
        nextCycle();

        // Backpressure: four reads with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 6'(10 + i), 32'h1000 + 32'(i), 1'b1);
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            seqAddr[i] = 6'(10 + i);
            seqData[i] = 32'h1000 + 32'(i);
        end
        runReadSeq(4, 6, "bp");

        // Streaming with rsp_ready high: pushes and pops overlap.
        seqAddr[4] = 6'd1;
        seqData[4] = 32'hDEADBEEF;
        seqAddr[5] = 6'd3;
        seqData[5] = 32'hA5;
        runReadSeq(6, 0, "stream");

        // Writes while the response FIFO is full.
        applyStimulus(1'b1, 1'b0, 6'd1, '0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 6'd3, '0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 6'd20, 32'h55, 1'b0);
        @(negedge clk);
        checkOutput("stallwr0_ready", 32'(req_ready), 32'd1);
        checkOutput("stallwr0_wr_en", 32'(ram_wr_en), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 6'd21, 32'h66, 1'b0);
        @(negedge clk);
        checkOutput("stallwr1_ready", 32'(req_ready), 32'd1);
        checkOutput("stallwr1_count", 32'(dut.u_rspFifo.count_o), 32'd2);
        checkOutput("stallwr1_head", rsp_rdata, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("drain0_data", rsp_rdata, 32'hDEADBEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("drain1_valid", 32'(rsp_valid), 32'd1);
        checkOutput("drain1_data", rsp_rdata, 32'hA5);
        nextCycle();
        @(negedge clk);
        checkOutput("drain_empty", 32'(rsp_valid), 32'd0);
        seqAddr[0] = 6'd20;
        seqData[0] = 32'h55;
        seqAddr[1] = 6'd21;
        seqData[1] = 32'h66;
        nextCycle();
        runReadSeq(2, 0, "wrback");

        // Reset the cycle after a read is accepted: its data must vanish.
        applyStimulus(1'b1, 1'b0, 6'd1, '0, 1'b1);
        @(negedge clk);
        checkOutput("rstmid_accept", 32'(req_ready), 32'd1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("rstmid_ready", 32'(req_ready), 32'd0);
        checkOutput("rstmid_rsp", 32'(rsp_valid), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'd3, '0, 1'b1);
        @(negedge clk);
        checkOutput("postrst_ready", 32'(req_ready), 32'd1);
        checkOutput("postrst_rsp0", 32'(rsp_valid), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("postrst_rsp1", 32'(rsp_valid), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("postrst_rsp2", 32'(rsp_valid), 32'd1);
        checkOutput("postrst_data", rsp_rdata, 32'hA5);
        nextCycle();
        @(negedge clk);
        checkOutput("postrst_rsp3", 32'(rsp_valid), 32'd0);
        nextCycle();

        checkOutput("rd_wr_exclusive", 32'(bothHigh), 32'd0);
        checkOutput("fifo_no_overflow", 32'(overflowSeen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
